// File: rtl/rpn_stack_alu.sv
// rpn_stack_alu: parametrised RPN stack calculator.
// A LIFO operand stack of DEPTH entries, each WIDTH bits wide. Push, pop,
// add, sub, mul, dup, swap and clear complete in one cycle. Div and mod use
// a restoring divider that produces one quotient bit per cycle. Errors are
// sticky: they park the FSM in ERR until reset.
// Build option: define RPN_SAT_EN to make add/mul/sub saturate instead of
// wrapping modulo 2^WIDTH.
module rpn_stack_alu #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 5
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic [WIDTH-1:0]           in_i,
  input  logic [3:0]                 op_i,
  input  logic                       apply_i,
  output logic                       ready_o,
  output logic [WIDTH-1:0]           tail_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       empty_o,
  output logic                       full_o,
  output logic                       valid_o,
  output logic [2:0]                 err_code_o
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int NW = $clog2(WIDTH + 1);

  localparam logic [3:0] OP_PUSH  = 4'd0;
  localparam logic [3:0] OP_POP   = 4'd1;
  localparam logic [3:0] OP_ADD   = 4'd2;
  localparam logic [3:0] OP_MUL   = 4'd3;
  localparam logic [3:0] OP_SUB   = 4'd4;
  localparam logic [3:0] OP_DIV   = 4'd5;
  localparam logic [3:0] OP_MOD   = 4'd6;
  localparam logic [3:0] OP_DUP   = 4'd7;
  localparam logic [3:0] OP_SWAP  = 4'd8;
  localparam logic [3:0] OP_CLEAR = 4'd9;

  localparam logic [2:0] ERR_NONE = 3'd0;
  localparam logic [2:0] ERR_OVF  = 3'd1;
  localparam logic [2:0] ERR_UDF  = 3'd2;
  localparam logic [2:0] ERR_DIV0 = 3'd3;
  localparam logic [2:0] ERR_ILL  = 3'd4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    ERR  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [2:0]       err_q, err_d;
  logic [WIDTH-1:0] stack_q [DEPTH];
  logic [WIDTH-1:0] stack_d [DEPTH];

  // Divider working registers: partial remainder, dividend shifting out /
  // quotient shifting in, divisor, step counter and which result to keep.
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [NW-1:0]    step_q, step_d;
  logic             mod_q, mod_d;

  logic             is_empty, is_full, has_two;
  logic [CW-1:0]    top_idx, sec_idx;
  logic [WIDTH-1:0] t_val, s_val;
  logic [WIDTH-1:0] add_res, mul_res, sub_res;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] rem_nx, quo_nx;

  logic             wr_a_en, wr_b_en;
  logic [CW-1:0]    wr_a_idx, wr_b_idx;
  logic [WIDTH-1:0] wr_a_data, wr_b_data;

  assign is_empty = (count_q == '0);
  assign is_full  = (count_q == CW'(DEPTH));
  assign has_two  = (count_q >= CW'(2));
  assign top_idx  = count_q - CW'(1);
  assign sec_idx  = count_q - CW'(2);

  // Fetch T and S; missing operands read as zero so tail shows 0 when empty.
  always_comb begin
    t_val = '0;
    s_val = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!is_empty && (CW'(i) == top_idx)) t_val = stack_q[i];
      if (has_two && (CW'(i) == sec_idx))   s_val = stack_q[i];
    end
  end

`ifdef RPN_SAT_EN
  logic [WIDTH:0]     sum_full;
  logic [2*WIDTH-1:0] prod_full;

  // Saturating arithmetic: overflow clamps to all-ones, negative sub to zero.
  always_comb begin
    sum_full  = {1'b0, t_val} + {1'b0, s_val};
    prod_full = {{WIDTH{1'b0}}, t_val} * {{WIDTH{1'b0}}, s_val};
    add_res   = sum_full[WIDTH] ? '1 : sum_full[WIDTH-1:0];
    mul_res   = (|prod_full[2*WIDTH-1:WIDTH]) ? '1 : prod_full[WIDTH-1:0];
    sub_res   = (s_val > t_val) ? '0 : (t_val - s_val);
  end
`else
  // Wrapping arithmetic: keep the low WIDTH bits of every result.
  always_comb begin
    add_res = t_val + s_val;
    mul_res = t_val * s_val;
    sub_res = t_val - s_val;
  end
`endif

  // One restoring-division step: try subtracting the divisor from the
  // remainder extended by the next dividend bit, keep it if no borrow.
  always_comb begin
    trial = {rem_q, quo_q[WIDTH-1]} - {1'b0, dvs_q};
    if (!trial[WIDTH]) begin
      rem_nx = trial[WIDTH-1:0];
      quo_nx = {quo_q[WIDTH-2:0], 1'b1};
    end else begin
      rem_nx = {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
      quo_nx = {quo_q[WIDTH-2:0], 1'b0};
    end
  end

  // Next-state logic: decode the command in IDLE, step the divider in DIV,
  // and hold everything in ERR. Errors leave the stack untouched.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    err_d     = err_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    step_d    = step_q;
    mod_d     = mod_q;
    wr_a_en   = 1'b0;
    wr_a_idx  = '0;
    wr_a_data = '0;
    wr_b_en   = 1'b0;
    wr_b_idx  = '0;
    wr_b_data = '0;

    case (state_q)
      IDLE: begin
        if (apply_i) begin
          case (op_i)
            OP_PUSH: begin
              if (is_full) begin
                state_d = ERR;
                err_d   = ERR_OVF;
              end else begin
                wr_a_en   = 1'b1;
                wr_a_idx  = count_q;
                wr_a_data = in_i;
                count_d   = count_q + CW'(1);
              end
            end
            OP_POP: begin
              if (is_empty) begin
                state_d = ERR;
                err_d   = ERR_UDF;
              end else begin
                count_d = top_idx;
              end
            end
            OP_ADD, OP_MUL, OP_SUB: begin
              if (!has_two) begin
                state_d = ERR;
                err_d   = ERR_UDF;
              end else begin
                wr_a_en   = 1'b1;
                wr_a_idx  = sec_idx;
                wr_a_data = (op_i == OP_ADD) ? add_res :
                            (op_i == OP_MUL) ? mul_res : sub_res;
                count_d   = top_idx;
              end
            end
            OP_DIV, OP_MOD: begin
              if (!has_two) begin
                state_d = ERR;
                err_d   = ERR_UDF;
              end else if (s_val == '0) begin
                state_d = ERR;
                err_d   = ERR_DIV0;
              end else begin
                state_d = DIV;
                rem_d   = '0;
                quo_d   = t_val;
                dvs_d   = s_val;
                step_d  = '0;
                mod_d   = (op_i == OP_MOD);
              end
            end
            OP_DUP: begin
              if (is_empty) begin
                state_d = ERR;
                err_d   = ERR_UDF;
              end else if (is_full) begin
                state_d = ERR;
                err_d   = ERR_OVF;
              end else begin
                wr_a_en   = 1'b1;
                wr_a_idx  = count_q;
                wr_a_data = t_val;
                count_d   = count_q + CW'(1);
              end
            end
            OP_SWAP: begin
              if (!has_two) begin
                state_d = ERR;
                err_d   = ERR_UDF;
              end else begin
                wr_a_en   = 1'b1;
                wr_a_idx  = top_idx;
                wr_a_data = s_val;
                wr_b_en   = 1'b1;
                wr_b_idx  = sec_idx;
                wr_b_data = t_val;
              end
            end
            OP_CLEAR: begin
              count_d = '0;
            end
            default: begin
              state_d = ERR;
              err_d   = ERR_ILL;
            end
          endcase
        end
      end
      DIV: begin
        rem_d  = rem_nx;
        quo_d  = quo_nx;
        step_d = step_q + NW'(1);
        if (step_q == NW'(WIDTH - 1)) begin
          wr_a_en   = 1'b1;
          wr_a_idx  = sec_idx;
          wr_a_data = mod_q ? rem_nx : quo_nx;
          count_d   = top_idx;
          state_d   = IDLE;
        end
      end
      ERR: begin
        state_d = ERR;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Merge the (at most two) entry writes of this cycle into the stack image.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      stack_d[i] = stack_q[i];
      if (wr_a_en && (CW'(i) == wr_a_idx)) stack_d[i] = wr_a_data;
      if (wr_b_en && (CW'(i) == wr_b_idx)) stack_d[i] = wr_b_data;
    end
  end

  // Control and divider registers; reset aborts any divide in flight.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      count_q <= '0;
      err_q   <= ERR_NONE;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      step_q  <= '0;
      mod_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      err_q   <= err_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      step_q  <= step_d;
      mod_q   <= mod_d;
    end
  end

  // Stack storage: contents are meaningless beyond count, so no reset needed.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < DEPTH; i++) begin
      stack_q[i] <= stack_d[i];
    end
  end

  assign ready_o    = (state_q == IDLE);
  assign tail_o     = t_val;
  assign count_o    = count_q;
  assign empty_o    = is_empty;
  assign full_o     = is_full;
  assign valid_o    = (state_q != ERR);
  assign err_code_o = err_q;

endmodule

// File: tb/tb_rpn_stack_alu.sv
// tb_rpn_stack_alu: scoreboard bench for rpn_stack_alu.
// The driver feeds one command per cycle into a queue-based calculator model
// and queues the expected visible state; monitors pop and compare after each
// clock edge (and on reset assertion). A second 16-bit, depth-8 instance
// checks the divider latency and result at a wider operand size.
module tb_rpn_stack_alu;

   localparam int W   = 8;
   localparam int D   = 5;
   localparam int CW  = $clog2(D + 1);
   localparam int W2  = 16;
   localparam int D2  = 8;
   localparam int CW2 = $clog2(D2 + 1);
   localparam longint MAXV = (longint'(1) << W) - 1;

   typedef struct {
      longint tail;
      int     count;
      bit     empty;
      bit     full;
      bit     valid;
      int     err;
      bit     ready;
   } exp_t;

   typedef struct {
      longint tail;
      int     count;
      bit     ready;
   } exp2_t;

   logic clk = 1'b0;

   logic          reset_i, apply_i;
   logic [W-1:0]  in_i;
   logic [3:0]    op_i;
   logic          ready_o, empty_o, full_o, valid_o;
   logic [W-1:0]  tail_o;
   logic [CW-1:0] count_o;
   logic [2:0]    err_code_o;

   logic           reset2, apply2;
   logic [W2-1:0]  in2;
   logic [3:0]     op2;
   logic           ready2, empty2, full2, valid2;
   logic [W2-1:0]  tail2;
   logic [CW2-1:0] count2;
   logic [2:0]     err2;

   int nTests = 0;
   int nFail  = 0;

   exp_t  expQ[$];
   string tagQ[$];
   exp2_t exp2Q[$];
   string tag2Q[$];

   longint mq[$];
   int     mErr;
   int     mBusy;
   int     mDivOp;
   longint mDivT, mDivS;

   // Free-running 100 MHz clock shared by both instances.
   always #5 clk = ~clk;

   rpn_stack_alu #(.WIDTH(W), .DEPTH(D)) dut (
      .clk_i      (clk),
      .reset_i    (reset_i),
      .in_i       (in_i),
      .op_i       (op_i),
      .apply_i    (apply_i),
      .ready_o    (ready_o),
      .tail_o     (tail_o),
      .count_o    (count_o),
      .empty_o    (empty_o),
      .full_o     (full_o),
      .valid_o    (valid_o),
      .err_code_o (err_code_o)
   );

   rpn_stack_alu #(.WIDTH(W2), .DEPTH(D2)) dut16 (
      .clk_i      (clk),
      .reset_i    (reset2),
      .in_i       (in2),
      .op_i       (op2),
      .apply_i    (apply2),
      .ready_o    (ready2),
      .tail_o     (tail2),
      .count_o    (count2),
      .empty_o    (empty2),
      .full_o     (full2),
      .valid_o    (valid2),
      .err_code_o (err2)
   );

   function automatic longint aluResult(int op, longint t, longint s);
      longint r;
      case (op)
         2: r = t + s;
         3: r = t * s;
         default: r = t - s;
      endcase
`ifdef RPN_SAT_EN
      if (r > MAXV) r = MAXV;
      if (r < 0) r = 0;
`else
      r = r & MAXV;
`endif
      return r;
   endfunction

   function automatic void modelReset();
      mq.delete();
      mErr  = 0;
      mBusy = 0;
   endfunction

   // Calculator semantics for one clock edge.
   function automatic void modelStep(bit ap, int op, longint val);
      int     n;
      longint t, s;
      if (mErr != 0) return;
      if (mBusy > 0) begin
         mBusy--;
         if (mBusy == 0) begin
            void'(mq.pop_back());
            void'(mq.pop_back());
            mq.push_back((mDivOp == 5) ? (mDivT / mDivS) : (mDivT % mDivS));
         end
         return;
      end
      if (!ap) return;
      n = mq.size();
      t = (n >= 1) ? mq[n-1] : 0;
      s = (n >= 2) ? mq[n-2] : 0;
      case (op)
         0: if (n == D) mErr = 1; else mq.push_back(val);
         1: if (n == 0) mErr = 2; else void'(mq.pop_back());
         2, 3, 4: begin
            if (n < 2) mErr = 2;
            else begin
               void'(mq.pop_back());
               void'(mq.pop_back());
               mq.push_back(aluResult(op, t, s));
            end
         end
         5, 6: begin
            if (n < 2) mErr = 2;
            else if (s == 0) mErr = 3;
            else begin
               mBusy  = W;
               mDivOp = op;
               mDivT  = t;
               mDivS  = s;
            end
         end
         7: if (n == 0) mErr = 2; else if (n == D) mErr = 1; else mq.push_back(t);
         8: begin
            if (n < 2) mErr = 2;
            else begin
               mq[n-1] = s;
               mq[n-2] = t;
            end
         end
         9: mq.delete();
         default: mErr = 4;
      endcase
   endfunction

   function automatic exp_t modelSnapshot();
      exp_t e;
      e.count = mq.size();
      e.tail  = (e.count > 0) ? mq[e.count-1] : 0;
      e.empty = (e.count == 0);
      e.full  = (e.count == D);
      e.valid = (mErr == 0);
      e.err   = mErr;
      e.ready = (mErr == 0) && (mBusy == 0);
      return e;
   endfunction

   // Drive one command for the next edge and queue the state expected after it.
   task automatic applyStimulus(input bit ap, input int op, input longint val, input string tag);
      @(negedge clk);
      apply_i = ap;
      op_i    = 4'(op);
      in_i    = W'(val);
      modelStep(ap, op, val);
      expQ.push_back(modelSnapshot());
      tagQ.push_back(tag);
   endtask

   task automatic idleCycle(input string tag);
      applyStimulus(1'b0, int'($urandom_range(0, 15)), longint'($urandom_range(0, 255)), tag);
   endtask

   // Pulse reset between edges: once checked right after assertion, once after the next edge.
   task automatic doReset(input string tag);
      @(negedge clk);
      apply_i = 1'b0;
      modelReset();
      expQ.push_back(modelSnapshot());
      tagQ.push_back(tag);
      modelStep(1'b0, 0, 0);
      expQ.push_back(modelSnapshot());
      tagQ.push_back({tag, "_idle"});
      reset_i = 1'b1;
      #3;
      reset_i = 1'b0;
   endtask

   task automatic checkOutput(input exp_t e, input string tag);
      nTests++;
      if (tail_o !== W'(e.tail) || count_o !== CW'(e.count) || empty_o !== e.empty ||
          full_o !== e.full || valid_o !== e.valid || err_code_o !== 3'(e.err) ||
          ready_o !== e.ready) begin
         nFail++;
         $display("[TB] FAIL %s: got tail=%0d count=%0d empty=%0b full=%0b valid=%0b err=%0d ready=%0b, expected tail=%0d count=%0d empty=%0b full=%0b valid=%0b err=%0d ready=%0b",
                  tag, tail_o, count_o, empty_o, full_o, valid_o, err_code_o, ready_o,
                  e.tail, e.count, e.empty, e.full, e.valid, e.err, e.ready);
      end
   endtask

   task automatic apply16(input bit ap, input int op, input longint val,
                          input longint eTail, input int eCount, input bit eReady, input string tag);
      exp2_t e;
      @(negedge clk);
      apply2 = ap;
      op2    = 4'(op);
      in2    = W2'(val);
      e.tail  = eTail;
      e.count = eCount;
      e.ready = eReady;
      exp2Q.push_back(e);
      tag2Q.push_back(tag);
   endtask

   task automatic check16(input exp2_t e, input string tag);
      nTests++;
      if (tail2 !== W2'(e.tail) || count2 !== CW2'(e.count) || ready2 !== e.ready || valid2 !== 1'b1) begin
         nFail++;
         $display("[TB] FAIL %s: got tail=%0d count=%0d ready=%0b valid=%0b, expected tail=%0d count=%0d ready=%0b valid=1",
                  tag, tail2, count2, ready2, valid2, e.tail, e.count, e.ready);
      end
   endtask

   // Monitor for the 8-bit instance: compare after every edge and on reset assertion.
   initial begin : monitor8
      forever begin
         @(posedge clk or posedge reset_i);
         #1;
         if (expQ.size() > 0) checkOutput(expQ.pop_front(), tagQ.pop_front());
      end
   end

   // Monitor for the 16-bit instance.
   initial begin : monitor16
      forever begin
         @(posedge clk);
         #1;
         if (exp2Q.size() > 0) check16(exp2Q.pop_front(), tag2Q.pop_front());
      end
   end

   // Directed scenarios, randomized episodes, then the wide divider run.
   initial begin : driver
      int r;
      longint q16, m16;
      reset_i = 1'b0;
      apply_i = 1'b0;
      op_i    = '0;
      in_i    = '0;
      reset2  = 1'b0;
      apply2  = 1'b0;
      op2     = '0;
      in2     = '0;
      modelReset();

      doReset("reset_init");
      repeat (5) applyStimulus(1'b1, 0, 4, "fill_push");
      applyStimulus(1'b1, 0, 4, "overflow_push");
      applyStimulus(1'b1, 1, 0, "apply_in_err");
      doReset("reset_after_overflow");

      applyStimulus(1'b1, 0, 7, "push7");
      applyStimulus(1'b1, 0, 86, "push86");
      applyStimulus(1'b1, 5, 0, "div_accept");
      repeat (W) idleCycle("div_busy");
      applyStimulus(1'b1, 0, 7, "push7_mod");
      applyStimulus(1'b1, 0, 86, "push86_mod");
      applyStimulus(1'b1, 6, 0, "mod_accept");
      repeat (W) idleCycle("mod_busy");

      doReset("reset_pre_div0");
      applyStimulus(1'b1, 0, 0, "push0");
      applyStimulus(1'b1, 0, 86, "push86_div0");
      applyStimulus(1'b1, 5, 0, "div_by_zero");
      idleCycle("div0_hold");
      doReset("reset_pre_dup");
      applyStimulus(1'b1, 7, 0, "dup_empty");
      doReset("reset_pre_illegal");
      applyStimulus(1'b1, 12, 0, "illegal_op");
      applyStimulus(1'b1, 0, 1, "apply_in_err_ill");

      doReset("reset_pre_arith");
      applyStimulus(1'b1, 0, 200, "push200");
      applyStimulus(1'b1, 0, 100, "push100");
      applyStimulus(1'b1, 2, 0, "add_wrap");
      applyStimulus(1'b1, 0, 3, "push3");
      applyStimulus(1'b1, 0, 1, "push1");
      applyStimulus(1'b1, 4, 0, "sub_wrap");
      applyStimulus(1'b1, 0, 20, "push20");
      applyStimulus(1'b1, 3, 0, "mul_wrap");

      doReset("reset_pre_swap");
      applyStimulus(1'b1, 0, 5, "push5");
      applyStimulus(1'b1, 0, 9, "push9");
      applyStimulus(1'b1, 8, 0, "swap_at_two");
      applyStimulus(1'b1, 7, 0, "dup");
      applyStimulus(1'b1, 9, 0, "clear");
      applyStimulus(1'b1, 9, 0, "clear_empty");

      doReset("reset_pre_abort");
      applyStimulus(1'b1, 0, 7, "push7_abort");
      applyStimulus(1'b1, 0, 86, "push86_abort");
      applyStimulus(1'b1, 5, 0, "div_accept_abort");
      idleCycle("abort_busy1");
      idleCycle("abort_busy2");
      applyStimulus(1'b1, 0, 99, "apply_while_busy");
      doReset("reset_mid_div");
      repeat (12) idleCycle("post_abort");

      for (int ep = 0; ep < 8; ep++) begin
         doReset("reset_random");
         for (int k = 0; k < 40; k++) begin
            r = int'($urandom_range(0, 99));
            if      (r < 35) applyStimulus(1'b1, 0, ($urandom_range(0, 3) == 0) ? longint'($urandom_range(0, 2)) : longint'($urandom_range(0, 255)), "rand_push");
            else if (r < 43) applyStimulus(1'b1, 1, 0, "rand_pop");
            else if (r < 50) applyStimulus(1'b1, 2, 0, "rand_add");
            else if (r < 56) applyStimulus(1'b1, 3, 0, "rand_mul");
            else if (r < 62) applyStimulus(1'b1, 4, 0, "rand_sub");
            else if (r < 68) applyStimulus(1'b1, 5, 0, "rand_div");
            else if (r < 73) applyStimulus(1'b1, 6, 0, "rand_mod");
            else if (r < 80) applyStimulus(1'b1, 7, 0, "rand_dup");
            else if (r < 87) applyStimulus(1'b1, 8, 0, "rand_swap");
            else if (r < 90) applyStimulus(1'b1, 9, 0, "rand_clear");
            else if (r < 97) idleCycle("rand_idle");
            else             applyStimulus(1'b1, int'($urandom_range(10, 15)), 0, "rand_illegal");
         end
      end
      doReset("reset_end8");

      @(negedge clk);
      reset2 = 1'b1;
      exp2Q.push_back('{tail: 0, count: 0, ready: 1'b1});
      tag2Q.push_back("w16_reset");
      @(negedge clk);
      reset2 = 1'b0;
      q16 = 1000 / 7;
      m16 = 60000 % 123;
      apply16(1'b1, 0, 7, 7, 1, 1'b1, "w16_push7");
      apply16(1'b1, 0, 1000, 1000, 2, 1'b1, "w16_push1000");
      apply16(1'b1, 5, 0, 1000, 2, 1'b0, "w16_div_accept");
      for (int k = 1; k <= W2; k++)
         apply16(k == 3, 0, 5, (k == W2) ? q16 : 1000, (k == W2) ? 1 : 2, k == W2, "w16_div_busy");
      apply16(1'b1, 0, 123, 123, 2, 1'b1, "w16_push123");
      apply16(1'b1, 0, 60000, 60000, 3, 1'b1, "w16_push60000");
      apply16(1'b1, 6, 0, 60000, 3, 1'b0, "w16_mod_accept");
      for (int k = 1; k <= W2; k++)
         apply16(1'b0, 0, 0, (k == W2) ? m16 : 60000, (k == W2) ? 2 : 3, k == W2, "w16_mod_busy");

      repeat (3) @(posedge clk);
      #2;
      nTests++;
      if (expQ.size() != 0 || exp2Q.size() != 0) begin
         nFail++;
         $display("[TB] FAIL scoreboard_drain: got %0d/%0d entries left, expected 0/0", expQ.size(), exp2Q.size());
      end
      $display("[TB] %0d tests run, %0d failed", nTests, nFail);
      $finish;
   end

endmodule

// File: doc/rpn_stack_alu.md
Name: rpn_stack_alu

Overview:
Parametrised successor to the 8-bit, depth-5 stack calculator. It holds a LIFO operand stack of DEPTH entries, each WIDTH bits wide. Single-cycle push, pop, add, sub, mul, dup, swap and clear operations execute on the stack. Div and mod run on a multi-cycle restoring divider with a ready handshake. Errors are sticky and reported through a valid flag and an error code. The block sits between the command front-end and the result display/trace path.

Parameters:
WIDTH, 8, operand/result width in bits (>=2)
DEPTH, 5, number of stack entries (>=2)

Ports:
clk  in  1  clock; all state updates on the rising edge
reset  in  1  asynchronous, active-high reset
in  in  WIDTH  operand for push
op  in  4  opcode (see Behaviour)
apply  in  1  execute op at this edge when ready=1
ready  out  1  1 = idle and able to accept apply
tail  out  WIDTH  top of stack; 0 when empty
count  out  $clog2(DEPTH+1)  current number of entries
empty  out  1  count==0
full  out  1  count==DEPTH
valid  out  1  0 once any error has occurred (sticky)
err_code  out  3  0 none, 1 overflow, 2 underflow, 3 div-by-zero, 4 illegal op

Behaviour:
- Reset (async, immediate): count=0, tail=0, empty=1, full=0, valid=1, err_code=0, ready=1, FSM=IDLE. Stack contents are don't-care.
- Reset mid-divide aborts the divide. No partial result is written.
- Operands: T = top entry, S = second entry. Binary ops pop T and S and push the result (count-1).
- Opcodes:
  - 0 push in
  - 1 pop
  - 2 add T+S
  - 3 mul T*S (low WIDTH bits)
  - 4 sub T-S (mod 2^WIDTH)
  - 5 div T/S
  - 6 mod T%S
  - 7 dup T
  - 8 swap T and S
  - 9 clear (count=0)
  - 10-15 illegal
- Add and sub wrap modulo 2^WIDTH.
- FSM has three states: IDLE, DIV, ERR.
- IDLE, apply=1:
  - Legal single-cycle op: updates at that edge; new tail/count visible immediately after the edge.
  - Op 5/6 with count>=2 and S!=0: latch T, S and the op; go to DIV; ready=0.
- DIV:
  - Runs one quotient bit per cycle, WIDTH cycles.
  - On the WIDTH-th edge after acceptance, writes the quotient or remainder in place of T and S, and returns to IDLE.
  - ready=0 for exactly WIDTH cycles. Total latency from accept edge to result visible is WIDTH edges.
  - tail, count and empty keep their pre-op values while busy.
- apply while ready=0 is ignored, not queued.
- apply=0 changes nothing.
- Error detection happens at the accept edge. On error the stack is unchanged, valid=0, err_code is latched, FSM goes to ERR.
  - Overflow: push or dup when full.
  - Underflow: pop or dup when empty; binary op or swap with count<2.
  - Div-by-zero: op 5/6 with S==0.
  - Illegal: op 10-15.
- ERR: all applies ignored; ready=0; only reset leaves ERR.
- Boundaries:
  - Push at count=DEPTH-1 sets full=1.
  - Clear on an empty stack is legal and a no-op.
  - Swap at count=2 is legal.
  - mul overflow wraps unless RPN_SAT_EN is defined.

Optional Feature:
Macro: RPN_SAT_EN.
- Defined: add, mul and sub saturate instead of wrapping.
  - add/mul results above 2^WIDTH-1 clamp to 2^WIDTH-1.
  - sub with S>T clamps to 0.
  - Saturation is not an error; valid stays 1.
- Undefined: modular wrap as specified above.

Test Plan (WIDTH=8, DEPTH=5 unless noted):
- Reset; push 4 ×5 -> full=1, count=5, valid=1. Sixth push -> valid=0, err_code=1, count=5. Assert reset -> empty=1, valid=1, err_code=0 before the next edge.
- Push 7, push 86, div -> ready low exactly 8 cycles, then tail=12, count=1. Repeat with mod -> tail=2.
- Push 0, push 86, div -> valid=0, err_code=3, tail=86, count=2. Op 7 on empty -> err_code=2. Op 12 -> err_code=4.
- Push 200, push 100, add -> tail=44 (wrap); with RPN_SAT_EN -> 255. Push 3, push 1, sub -> 254; with RPN_SAT_EN -> 0.
- Push 5, push 9, swap -> tail=5; dup -> tail=5, count=3; clear -> empty=1, valid=1.
- Start a div, assert reset on busy cycle 4 -> count=0, ready=1, no later write. Apply during busy -> ignored. Repeat the div test with WIDTH=16, DEPTH=8 -> ready low 16 cycles, correct quotient.
